color_num_select: RTL and testbench

COLOR_NUM_SELECT -- requirements
Module: color_num_select

---
 rtl/color_num_select.sv | 140 ++++++++++++++
 tb/tb_color_num_select.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/color_num_select.sv
// color_num_select: setup-phase front end for the color game.
// Four raw push buttons are synchronized, debounced and edge-detected; a
// two-state FSM uses the resulting press pulses to pick a color count in
// the range 3..8 (live preview) and to lock it in when a game starts.
module color_num_select #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       btn_restart,
  output logic [3:0] final_COLOR_NUM,
  output logic       color_locked,
  output logic       start_pulse
);

  // Button vector bit positions.
  localparam int unsigned B_UP      = 0;
  localparam int unsigned B_DOWN    = 1;
  localparam int unsigned B_CONFIRM = 2;
  localparam int unsigned B_RESTART = 3;
  localparam int unsigned NBTN      = 4;

  // FSM encodings.
  localparam logic [0:0] SELECT = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Selection limits.
  localparam logic [3:0] NUM_MIN = 4'd3;
  localparam logic [3:0] NUM_MAX = 4'd8;

  // Last count value before the debounced level flips.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  db_level;
  logic [NBTN-1:0]  db_prev;
  logic [NBTN-1:0]  press;
  logic [CNT_W-1:0] db_cnt [NBTN];

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [3:0] sel_num;
  logic [3:0] sel_nxt;

  assign btn_raw = {btn_restart, btn_confirm, btn_down, btn_up};

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the level follows the synchronized input only after
  // DB_CYCLES consecutive mismatching cycles; any agreeing cycle restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2[i] != db_level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_level[i] <= sync2[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev <= '0;
    end else begin
      db_prev <= db_level;
    end
  end

  // One-cycle press pulse on each debounced 0->1 transition.
  assign press = db_level & ~db_prev;

  // Next-state and selection update; confirm outranks up/down, and
  // simultaneous up/down cancel out.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_num;
    case (state)
      SELECT: begin
        if (press[B_CONFIRM]) begin
          state_nxt = LOCKED;
        end else if (press[B_UP] && !press[B_DOWN]) begin
          if (sel_num < NUM_MAX) sel_nxt = sel_num + 4'd1;
        end else if (press[B_DOWN] && !press[B_UP]) begin
          if (sel_num > NUM_MIN) sel_nxt = sel_num - 4'd1;
        end
      end
      LOCKED: begin
        if (press[B_RESTART]) state_nxt = SELECT;
      end
      default: state_nxt = SELECT;
    endcase
  end

  // State, selection and registered outputs; outputs load from the same
  // next values so they land on the same edge as the internal state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SELECT;
      sel_num         <= NUM_MIN;
      final_COLOR_NUM <= NUM_MIN;
      color_locked    <= 1'b0;
      start_pulse     <= 1'b0;
    end else begin
      state           <= state_nxt;
      sel_num         <= sel_nxt;
      final_COLOR_NUM <= sel_nxt;
      color_locked    <= (state_nxt == LOCKED);
      start_pulse     <= (state == SELECT) && (state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_color_num_select.sv
// Directed bench for color_num_select with a short debounce window.
module tb_color_num_select;

  logic       clk;
  logic       rst_n;
  logic       btn_up;
  logic       btn_down;
  logic       btn_confirm;
  logic       btn_restart;
  logic [3:0] final_COLOR_NUM;
  logic       color_locked;
  logic       start_pulse;

  int unsigned n_chk;
  int unsigned n_err;
  logic        found;

  color_num_select #(
    .DB_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_confirm(btn_confirm),
    .btn_restart(btn_restart),
    .final_COLOR_NUM(final_COLOR_NUM),
    .color_locked(color_locked),
    .start_pulse(start_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 ns later.
  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive {restart,confirm,down,up} for 'hold' cycles, then release for 10.
  task automatic press(input logic [3:0] b, input int unsigned hold);
    {btn_restart, btn_confirm, btn_down, btn_up} = b;
    cyc(hold);
    {btn_restart, btn_confirm, btn_down, btn_up} = 4'b0000;
    cyc(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    {btn_restart, btn_confirm, btn_down, btn_up} = 4'b0000;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_num", 8'(final_COLOR_NUM), 8'd3);
    chk("rst_lock", 8'(color_locked), 8'd0);
    chk("rst_start", 8'(start_pulse), 8'd0);
    rst_n = 1'b1;
    cyc(2);

    // Six clean up presses, saturating at 8.
    press(4'b0001, 10); chk("up1", 8'(final_COLOR_NUM), 8'd4);
    press(4'b0001, 10); chk("up2", 8'(final_COLOR_NUM), 8'd5);
    press(4'b0001, 10); chk("up3", 8'(final_COLOR_NUM), 8'd6);
    press(4'b0001, 10); chk("up4", 8'(final_COLOR_NUM), 8'd7);
    press(4'b0001, 10); chk("up5", 8'(final_COLOR_NUM), 8'd8);
    press(4'b0001, 10); chk("up6_sat", 8'(final_COLOR_NUM), 8'd8);
    cyc(20);
    chk("up_stay8", 8'(final_COLOR_NUM), 8'd8);

    // Glitchy press: 3-cycle bounces must not count.
    do_reset();
    chk("rst2_num", 8'(final_COLOR_NUM), 8'd3);
    btn_up = 1'b1; cyc(3); btn_up = 1'b0; cyc(3);
    btn_up = 1'b1; cyc(3); btn_up = 1'b0; cyc(3);
    chk("glitch_none", 8'(final_COLOR_NUM), 8'd3);
    press(4'b0001, 10);
    chk("glitch_one", 8'(final_COLOR_NUM), 8'd4);

    // Up and down together cancel.
    press(4'b0011, 10);
    chk("updown_cancel", 8'(final_COLOR_NUM), 8'd4);

    // Long down hold gives a single decrement; then saturate at 3.
    press(4'b0001, 10);
    chk("to5", 8'(final_COLOR_NUM), 8'd5);
    btn_down = 1'b1;
    cyc(50);
    chk("hold_mid", 8'(final_COLOR_NUM), 8'd4);
    cyc(50);
    chk("hold_end", 8'(final_COLOR_NUM), 8'd4);
    btn_down = 1'b0;
    cyc(10);
    press(4'b0010, 10); chk("down_to3", 8'(final_COLOR_NUM), 8'd3);
    press(4'b0010, 10); chk("down_sat", 8'(final_COLOR_NUM), 8'd3);

    // Climb to 6, then up+confirm together: confirm wins.
    press(4'b0001, 10);
    press(4'b0001, 10);
    press(4'b0001, 10);
    chk("at6", 8'(final_COLOR_NUM), 8'd6);
    chk("unlocked", 8'(color_locked), 8'd0);
    {btn_confirm, btn_up} = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        cyc(1);
        if (color_locked) found = 1'b1;
      end
    end
    chk("lock_seen", 8'(found), 8'd1);
    chk("start_first", 8'(start_pulse), 8'd1);
    chk("lock_num6", 8'(final_COLOR_NUM), 8'd6);
    cyc(1);
    chk("start_once", 8'(start_pulse), 8'd0);
    chk("lock_hold", 8'(color_locked), 8'd1);
    {btn_confirm, btn_up} = 2'b00;
    cyc(10);

    // Presses ignored while locked.
    press(4'b0001, 10); chk("lk_up", 8'(final_COLOR_NUM), 8'd6);
    press(4'b0010, 10); chk("lk_down", 8'(final_COLOR_NUM), 8'd6);
    press(4'b0100, 10); chk("lk_conf", 8'(color_locked), 8'd1);
    chk("lk_conf_start", 8'(start_pulse), 8'd0);
    press(4'b1000, 10);
    chk("rs_unlock", 8'(color_locked), 8'd0);
    chk("rs_keep", 8'(final_COLOR_NUM), 8'd6);
    press(4'b1000, 10);
    chk("rs_sel_noop", 8'(color_locked), 8'd0);
    press(4'b0001, 10);
    chk("rs_up7", 8'(final_COLOR_NUM), 8'd7);

    // Reset while locked at 7 acts immediately.
    press(4'b0100, 10);
    chk("lock7", 8'(color_locked), 8'd1);
    chk("lock7_num", 8'(final_COLOR_NUM), 8'd7);
    rst_n = 1'b0;
    #1;
    chk("arst_num", 8'(final_COLOR_NUM), 8'd3);
    chk("arst_lock", 8'(color_locked), 8'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Reset mid-debounce with the button still held after release.
    btn_up = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    chk("held_early", 8'(final_COLOR_NUM), 8'd3);
    cyc(2);
    chk("held_after", 8'(final_COLOR_NUM), 8'd4);
    cyc(10);
    chk("held_once", 8'(final_COLOR_NUM), 8'd4);
    btn_up = 1'b0;
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
